// File: rtl/fc_pkg.sv
// Shared constants, types and constant weight/bias tables for the stage-3 fully-connected classifier.
package fc_pkg;
    localparam int N_IN   = 144;
    localparam int N_OUT  = 4;
    localparam int IN_W   = 36;
    localparam int W_W    = 16;
    localparam int ACC_W  = 60;
    localparam int PROD_W = IN_W + W_W;
    localparam int N_W    = $clog2(N_OUT);
    localparam int I_W    = $clog2(N_IN);

    typedef logic signed [IN_W-1:0]   act_t;
    typedef logic signed [W_W-1:0]    weight_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic [N_W-1:0]           nidx_t;
    typedef logic [I_W-1:0]           iidx_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MAC    = 2'd1;
    localparam logic [1:0] ARGMAX = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_MAC    = MAC,
        ST_ARGMAX = ARGMAX,
        ST_DONE   = DONE
    } fc_state_t;

    // Last neuron reuses neuron 2's row in reverse order, so a uniform input ties them.
    function automatic weight_t fc_weight(input int n, input int i);
        int row;
        int col;
        int v;
        row = (n == N_OUT - 1) ? N_OUT - 2 : n;
        col = (n == N_OUT - 1) ? N_IN - 1 - i : i;
        v = ((col * 73 + row * 151) % 401) - 200;
        if (row == 1) begin
            v = -v;
        end else if (row == 2) begin
            v = v + 1000;
        end
        return weight_t'(v);
    endfunction

    function automatic weight_t fc_bias(input int n);
        int v;
        case (n)
            0:       v = -300;
            1:       v = 500;
            default: v = 700;
        endcase
        return weight_t'(v);
    endfunction
endpackage

// File: rtl/fc_weights_rom.sv
// Combinational constant ROM: weight w[n][i] and bias b[n], tables folded at elaboration.
module fc_weights_rom
    import fc_pkg::*;
(
    input  nidx_t   n,
    input  iidx_t   i,
    output weight_t w,
    output weight_t b
);
    weight_t w_tab [N_OUT][N_IN];
    weight_t b_tab [N_OUT];

    for (genvar gn = 0; gn < N_OUT; gn++) begin : g_row
        assign b_tab[gn] = fc_bias(gn);
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_col
            assign w_tab[gn][gi] = fc_weight(gn, gi);
        end
    end

    assign w = w_tab[n][i];
    assign b = b_tab[n];
endmodule

// File: rtl/etapa3_fc.sv
// Stage-3 fully-connected classifier: serial MAC over a snapshot of stage-2 results, then argmax.
// Optional build macro FC_RELU_EN clamps negative activations to zero when the snapshot is taken.
module etapa3_fc
    import fc_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  act_t  s2_in [N_IN],
    output logic  busy,
    output logic  done,
    output acc_t  scores [N_OUT],
    output nidx_t class_idx
);
    localparam iidx_t I_LAST = iidx_t'(N_IN - 1);
    localparam nidx_t N_LAST = nidx_t'(N_OUT - 1);

    fc_state_t state;
    act_t      snap [N_IN];
    acc_t      acc;
    acc_t      best;
    nidx_t     best_idx;
    nidx_t     n_cnt;
    nidx_t     k_cnt;
    iidx_t     i_cnt;
    weight_t   w_cur;
    weight_t   b_cur;
    prod_t     prod;
    acc_t      acc_next;
    logic      k_wins;

    fc_weights_rom u_rom (
        .n (n_cnt),
        .i (i_cnt),
        .w (w_cur),
        .b (b_cur)
    );

    always_comb begin
        prod     = prod_t'(snap[i_cnt]) * prod_t'(w_cur);
        acc_next = acc + acc_t'(prod);
        k_wins   = scores[k_cnt] > best;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            n_cnt     <= '0;
            k_cnt     <= '0;
            i_cnt     <= '0;
            class_idx <= '0;
            for (int j = 0; j < N_IN; j++) snap[j] <= '0;
            for (int j = 0; j < N_OUT; j++) scores[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // While done is still high, busy covers that cycle and start is refused.
                    if (start && !done) begin
                        for (int j = 0; j < N_IN; j++) begin
`ifdef FC_RELU_EN
                            snap[j] <= s2_in[j][IN_W-1] ? '0 : s2_in[j];
`else
                            snap[j] <= s2_in[j];
`endif
                        end
                        acc   <= '0;
                        n_cnt <= '0;
                        i_cnt <= '0;
                        busy  <= 1'b1;
                        state <= ST_MAC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_MAC: begin
                    if (i_cnt == I_LAST) begin
                        scores[n_cnt] <= acc_next + acc_t'(b_cur);
                        acc   <= '0;
                        i_cnt <= '0;
                        if (n_cnt == N_LAST) begin
                            n_cnt <= '0;
                            k_cnt <= '0;
                            state <= ST_ARGMAX;
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                ST_ARGMAX: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (k_cnt == '0) begin
                        best     <= scores[0];
                        best_idx <= '0;
                    end else if (k_wins) begin
                        best     <= scores[k_cnt];
                        best_idx <= k_cnt;
                    end
                    if (k_cnt == N_LAST) begin
                        class_idx <= k_wins ? k_cnt : best_idx;
                        state     <= ST_DONE;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_etapa3_fc.sv
// Directed bench for etapa3_fc: latency, scores, argmax, ReLU option, ignored start, reset abort.
module tb_etapa3_fc;
    import fc_pkg::*;

    logic  clk;
    logic  reset;
    logic  start;
    act_t  s2_in [N_IN];
    logic  busy;
    logic  done;
    acc_t  scores [N_OUT];
    nidx_t class_idx;

    int     tests_run;
    int     tests_failed;
    longint x_ref [N_IN];
    longint exp_s [N_OUT];
    int     exp_idx;

    etapa3_fc dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s2_in     (s2_in),
        .busy      (busy),
        .done      (done),
        .scores    (scores),
        .class_idx (class_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model built from the shared ROM tables.
    task automatic compute_ref();
        longint xv;
        longint best;
        for (int n = 0; n < N_OUT; n++) begin
            exp_s[n] = longint'(fc_bias(n));
            for (int i = 0; i < N_IN; i++) begin
                xv = x_ref[i];
`ifdef FC_RELU_EN
                if (xv < 0) xv = 0;
`endif
                exp_s[n] += xv * longint'(fc_weight(n, i));
            end
        end
        best = exp_s[0];
        exp_idx = 0;
        for (int n = 1; n < N_OUT; n++) begin
            if (exp_s[n] > best) begin
                best = exp_s[n];
                exp_idx = n;
            end
        end
    endtask

    task automatic clear_x();
        for (int i = 0; i < N_IN; i++) x_ref[i] = 0;
    endtask

    task automatic run_case(input string tag, input bit inject);
        int cyc;
        int lat;
        int n_done;
        int busy_gap;
        compute_ref();
        for (int i = 0; i < N_IN; i++) s2_in[i] = act_t'(x_ref[i]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        lat = -1;
        n_done = 0;
        busy_gap = 0;
        while (cyc < 700) begin
            @(posedge clk);
            #1;
            cyc++;
            if (start) start = 1'b0;
            if (inject && cyc == 100) begin
                start = 1'b1;
                for (int i = 0; i < N_IN; i++) s2_in[i] = act_t'({$urandom(), $urandom()});
            end
            if (done) begin
                n_done++;
                if (lat < 0) begin
                    lat = cyc;
                    start = 1'b1;
                end
            end
            if ((lat < 0 || cyc == lat) && !busy) busy_gap++;
            if (lat > 0 && (cyc == lat + 1 || cyc == lat + 2)) begin
                check({tag, "_busy_after"}, busy, 0);
                check({tag, "_done_after"}, done, 0);
            end
        end
        check({tag, "_latency"}, lat, 581);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_gap"}, busy_gap, 0);
        for (int n = 0; n < N_OUT; n++)
            check($sformatf("%s_score%0d", tag, n), longint'(scores[n]), exp_s[n]);
        check({tag, "_class_idx"}, class_idx, exp_idx);
    endtask

    initial begin
        int n_done;
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < N_IN; i++) s2_in[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_class_idx", class_idx, 0);
        for (int n = 0; n < N_OUT; n++) check($sformatf("rst_score%0d", n), longint'(scores[n]), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero input: scores are the biases, ties resolve to index 2.
        clear_x();
        run_case("zero", 1'b0);
        check("zero_hand_s0", longint'(scores[0]), -300);
        check("zero_hand_s1", longint'(scores[1]), 500);
        check("zero_hand_s2", longint'(scores[2]), 700);
        check("zero_hand_s3", longint'(scores[3]), 700);
        check("zero_hand_idx", class_idx, 2);

        // Single unit input at index 0.
        clear_x();
        x_ref[0] = 1;
        run_case("unit0", 1'b0);
        check("unit0_hand_s0", longint'(scores[0]), -500);
        check("unit0_hand_s1", longint'(scores[1]), 549);
        check("unit0_hand_s2", longint'(scores[2]), 1802);
        check("unit0_hand_s3", longint'(scores[3]), 1815);
        check("unit0_hand_idx", class_idx, 3);

        // Negative input at index 5, sensitive to the ReLU option.
        clear_x();
        x_ref[5] = -1000;
        run_case("neg5", 1'b0);
`ifdef FC_RELU_EN
        check("neg5_hand_s0", longint'(scores[0]), -300);
        check("neg5_hand_s3", longint'(scores[3]), 700);
        check("neg5_hand_idx", class_idx, 2);
`else
        check("neg5_hand_s0", longint'(scores[0]), -165300);
        check("neg5_hand_s1", longint'(scores[1]), -84500);
        check("neg5_hand_s2", longint'(scores[2]), -1065300);
        check("neg5_hand_s3", longint'(scores[3]), -1150300);
        check("neg5_hand_idx", class_idx, 1);
`endif

        // Every input at max positive: large sums, neurons 2 and 3 tie.
        for (int i = 0; i < N_IN; i++) x_ref[i] = 64'sd34359738367;
        run_case("maxpos", 1'b0);
        check("maxpos_tie_idx", class_idx, 2);

        // Second start mid-run and changing inputs are ignored.
        for (int i = 0; i < N_IN; i++) x_ref[i] = longint'(i - 70) * 12345;
        run_case("ignore", 1'b1);

        // Reset pulse during MAC aborts the run.
        clear_x();
        x_ref[3] = 777;
        x_ref[100] = -4321;
        for (int i = 0; i < N_IN; i++) s2_in[i] = act_t'(x_ref[i]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_class_idx", class_idx, 0);
        for (int n = 0; n < N_OUT; n++) check($sformatf("abort_score%0d", n), longint'(scores[n]), 0);
        n_done = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_case("after_abort", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/etapa3_fc.md
# etapa3_fc

Fully-connected classification stage that sits directly downstream of the stage-2 convolution block. It snapshots the 144 signed 36-bit convolution results when stage 2 signals completion. It then runs a serial multiply-accumulate of those results against a constant weight ROM to produce `N_OUT` class scores, and reports the index of the largest score. All work uses one multiplier, iterated by an FSM over neurons and inputs.

## Interface
Parameters:
- `N_IN`, 144, number of input activations (4 filters × 6×6 outputs of stage 2)
- `N_OUT`, 4, number of output neurons (classes)
- `IN_W`, 36, signed width of each input activation
- `W_W`, 16, signed width of weights and biases
- `ACC_W`, 60, signed accumulator and score width (`IN_W + W_W + ceil(log2 N_IN)`)

Ports:
- `clk`  in  1  system clock; one clock for the whole block
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse from stage 2 indicating `s2_in` is valid
- `s2_in`  in  `IN_W` × `N_IN` (signed array)  stage-2 convolution results
- `busy`  out  1  high while a classification is in progress
- `done`  out  1  one-cycle pulse; `scores` and `class_idx` are valid and held from this cycle on
- `scores`  out  `ACC_W` × `N_OUT` (signed array)  final neuron outputs including bias
- `class_idx`  out  `$clog2(N_OUT)`  index of the maximum score

## Operation
- FSM states are `IDLE`, `MAC`, `ARGMAX` and `DONE`.
- IDLE:
  - On `start`=1, copy all of `s2_in` into an internal snapshot register.
  - Clear the accumulator, set neuron counter n=0 and input counter i=0, then go to MAC.
  - `start` is ignored in every other state.
- MAC, one product per cycle:
  - `acc <= acc + x[i]*w[n][i]`, where x is the snapshot.
  - At i=`N_IN`-1: `scores[n] <= acc + x[i]*w[n][i] + sign_ext(b[n])`, `acc <= 0`, i wraps to 0 and n increments.
  - After n=`N_OUT`-1 completes, go to ARGMAX.
- ARGMAX, one comparison per cycle over k=0..`N_OUT`-1:
  - `best` starts at `scores[0]` with index 0.
  - Replace only on strictly greater, so ties resolve to the lowest index.
  - After k=`N_OUT`-1, write `class_idx` and go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- Arithmetic:
  - All signed, full precision, no saturation or rounding.
  - Each product is `IN_W+W_W` = 52 bits, sign-extended to `ACC_W`.
  - The bias is sign-extended to `ACC_W`.
- Reset (`reset`=0):
  - State goes to IDLE.
  - `busy`, `done`, all `scores`, `class_idx`, the accumulator, the counters and the snapshot all go to 0.
  - Reset during MAC or ARGMAX aborts the run: no `done` is produced and partial scores are discarded (held at 0).
- `scores` and `class_idx` update only during a run and stay stable from `done` until the next run overwrites them. `scores[n]` is written at the end of neuron n.

## Timing
- `start` is sampled at rising edge E0 and the snapshot is taken at E0.
- `busy` is 1 from the cycle after E0 through the `done` cycle inclusive, and 0 in IDLE.
- MAC occupies `N_IN*N_OUT` = 576 cycles. ARGMAX occupies `N_OUT` = 4 cycles.
- `done` is high in the cycle starting at edge E0+581 (1 + 576 + 4), for exactly one cycle.
- A `start` arriving in the `done` cycle is ignored. The block accepts a new `start` from the following cycle.
- `s2_in` may change freely after E0.

## Configuration
- `FC_RELU_EN`:
  - Defined: each element is clamped to 0 at snapshot time if negative (ReLU on the stage-2 outputs).
  - Undefined: the raw signed values are stored.
- Nothing else changes, including latency.

## Structure
- Shared package `fc_pkg`:
  - Constants `N_IN`, `N_OUT`, `IN_W`, `W_W`, `ACC_W`.
  - Typedefs `act_t` (signed `IN_W`), `weight_t` (signed `W_W`), `acc_t` (signed `ACC_W`).
  - FSM state enum `fc_state_t`.
- One sub-module, `fc_weights_rom`:
  - Combinational constant ROM, inputs n and i.
  - Outputs `w[n][i]` and `b[n]`.
  - It mirrors the stage-2 filter ROM style.
- The bench reads the same ROM contents to build its reference model.

## Test plan
- All `s2_in`=0, `start` pulse → `done` exactly 581 cycles after the start edge; `scores[n]`=`b[n]`; `class_idx` = first index of the maximum bias.
- `s2_in[0]`=1, others 0 → `scores[n]`=`w[n][0]`+`b[n]` for every n; `class_idx` matches the reference model.
- `s2_in[5]`=-1000, others 0, with and without `FC_RELU_EN` → defined: `scores[n]`=`b[n]`; undefined: `scores[n]`=-1000·`w[n][5]`+`b[n]`.
- Every input at max positive 2^35-1 → scores match the 60-bit reference with no overflow; ties in scores resolve to the lowest index.
- Second `start` at cycle 100 of a run, and `s2_in` changed after E0 → ignored; a single `done` at 581; results reflect the original snapshot.
- `reset`=0 for one cycle at cycle 300 of MAC → next cycle `busy`=0, scores 0, `class_idx`=0; no `done`; a fresh `start` then completes normally in 581 cycles.
